// File: rtl/board_input_ctrl.sv
// Board input conditioner: synchronizes and debounces slide switches and push buttons,
// emits one-cycle press/release/change pulses and drives the display page selector.
module board_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 2000000,
    parameter int N_PAGES         = 6,
    parameter int SEL_BTN         = 6
) (
    input  logic        clk,
    input  logic        Rst_n,
    input  logic [1:32] sw_raw,
    input  logic [1:6]  swb_raw,
    output logic [1:32] sw_out,
    output logic        sw_changed,
    output logic [1:6]  btn_level,
    output logic [1:6]  btn_press,
    output logic [1:6]  btn_release,
    output logic [2:0]  page_sel,
    output logic        page_valid
);

    localparam int            CW        = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]    PAGE_LAST = 3'(N_PAGES - 1);

    typedef enum logic [1:0] {
        UP,
        UP_CHK,
        DOWN,
        DN_CHK
    } btn_state_t;

    logic [1:32]   sw_meta;
    logic [1:32]   sw_sync;
    logic [1:6]    btn_meta;
    logic [1:6]    btn_sync;
    logic [1:32]   cand;
    logic [CW-1:0] sw_cnt;

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            btn_meta <= '0;
            btn_sync <= '0;
        end else begin
            sw_meta  <= sw_raw;
            sw_sync  <= sw_meta;
            btn_meta <= swb_raw;
            btn_sync <= btn_meta;
        end
    end

    // One counter for the whole switch vector: any bit moving restarts the stability window.
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cand       <= '0;
            sw_cnt     <= '0;
            sw_out     <= '0;
            sw_changed <= 1'b0;
        end else begin
            sw_changed <= 1'b0;
            if (sw_sync != cand) begin
                cand   <= sw_sync;
                sw_cnt <= '0;
            end else if (sw_cnt != CNT_MAX) begin
                sw_cnt <= sw_cnt + 1'b1;
            end else if (cand != sw_out) begin
                sw_out     <= cand;
                sw_changed <= 1'b1;
            end
        end
    end

    for (genvar i = 1; i <= 6; i++) begin : g_btn
        btn_state_t    state;
        logic [CW-1:0] cnt;
        logic          level_q;
        logic          press_q;
        logic          release_q;

        // A bounce on the qualifying cycle sends the FSM back before the count is honoured.
        always_ff @(posedge clk or negedge Rst_n) begin
            if (!Rst_n) begin
                state     <= UP;
                cnt       <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
                case (state)
                    UP: begin
                        if (btn_sync[i]) begin
                            state <= UP_CHK;
                            cnt   <= '0;
                        end
                    end
                    UP_CHK: begin
                        if (!btn_sync[i]) begin
                            state <= UP;
                        end else if (cnt == CNT_MAX) begin
                            state   <= DOWN;
                            level_q <= 1'b1;
                            press_q <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    DOWN: begin
                        if (!btn_sync[i]) begin
                            state <= DN_CHK;
                            cnt   <= '0;
                        end
                    end
                    DN_CHK: begin
                        if (btn_sync[i]) begin
                            state <= DOWN;
                        end else if (cnt == CNT_MAX) begin
                            state     <= UP;
                            level_q   <= 1'b0;
                            release_q <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: state <= UP;
                endcase
            end
        end

        assign btn_level[i]   = level_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;
    end

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            page_sel <= '0;
        end else if (btn_press[SEL_BTN]) begin
            page_sel <= (page_sel == PAGE_LAST) ? 3'd0 : page_sel + 3'd1;
        end
    end

    // The last page is the blank test page.
    assign page_valid = (page_sel != PAGE_LAST);

endmodule
